// File: rtl/zxd_pkg.sv
// rtl/zxd_pkg.sv - phase encoding, FIFO entry type and slot-width helper for the zxd SRAM arbiter
package zxd_pkg;

  typedef enum logic [1:0] {
    PH_VRD0   = 2'd0,
    PH_VRD1   = 2'd1,
    PH_WSET   = 2'd2,
    PH_WPULSE = 2'd3
  } phase_e;

  localparam int DL_AW = 25;

  // addr holds the already-masked offset into the screen area, not the raw ioctl address
  typedef struct packed {
    logic [DL_AW-1:0] addr;
    logic [7:0]       data;
  } fifo_entry_t;

  function automatic int slot_w(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with full/empty and push-while-full when a pop coincides
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  // pointers carry one extra wrap bit to tell full from empty
  assign empty_o    = (wr_q == rd_q);
  assign full_o     = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_q[PW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (PW+1)'(1);
    if (do_pop)  rd_d = rd_q + (PW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/zxd_sram_arbiter.sv
// rtl/zxd_sram_arbiter.sv - time-slices each pixel-enable period into a video read and a buffered download write
module zxd_sram_arbiter
  import zxd_pkg::*;
#(
  parameter int            AW         = 21,
  parameter int            SCREEN_AW  = 13,
  parameter int            SLOTS      = 4,
  parameter logic [AW-1:0] BASE       = '0,
  parameter int            FIFO_DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      frame,
  input  logic [slot_w(SLOTS)-1:0]  slot,
  input  logic [SCREEN_AW-1:0]      vidA,
  output logic [7:0]                vidQ,
  input  logic                      dlB,
  input  logic                      dlW,
  input  logic [24:0]               dlA,
  input  logic [7:0]                dlD,
  output logic                      busy,
  output logic                      overflow,
  output logic [AW-1:0]             sramA,
  output logic                      sramOe,
  output logic                      sramWe,
  output logic [7:0]                sramDo,
  output logic                      sramDoe,
  input  logic [7:0]                sramDi
);

  localparam int                SW        = slot_w(SLOTS);
  localparam int                WOFF_W    = SCREEN_AW + $clog2(SLOTS);
  localparam logic [SW-1:0]     SLOT_MASK = SW'(SLOTS - 1);
  localparam logic [DL_AW-1:0]  WMASK     = DL_AW'((64'd1 << WOFF_W) - 64'd1);

  phase_e          ph_q, ph_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [7:0]      vid_q, vid_d;
  logic            ovf_q, ovf_d;
  logic            dl_b_q;
  logic [AW-1:0]   sram_a_q, sram_a_d;
  logic            sram_oe_q, sram_oe_d;
  logic            sram_we_q, sram_we_d;
  logic [7:0]      sram_do_q, sram_do_d;
  logic            sram_doe_q, sram_doe_d;

  fifo_entry_t     push_entry, head;
  logic            fifo_full, fifo_empty;
  logic            push_req, push_ok, drop, pop;
  logic [AW-1:0]   vid_off;

  assign push_req   = dlW & dlB;
  assign push_ok    = push_req & (~fifo_full | pop);
  assign drop       = push_req & ~push_ok;
  assign push_entry = '{addr: dlA & WMASK, data: dlD};

  // the entry only leaves once its WE pulse has run to the end of the period
  assign pop = ce && (ph_q == PH_WPULSE) && !sram_we_q;

  sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clock),
    .rst_ni      (reset),
    .push_i      (push_ok),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign vid_off = AW'(vidA) | (AW'(slot_q) << SCREEN_AW);

  always_comb begin
    ph_d       = ph_q;
    sram_a_d   = sram_a_q;
    sram_oe_d  = sram_oe_q;
    sram_we_d  = sram_we_q;
    sram_do_d  = sram_do_q;
    sram_doe_d = sram_doe_q;

    if (ce)                     ph_d = PH_VRD0;
    else if (ph_q != PH_WPULSE) ph_d = phase_e'(ph_q + 2'd1);

    // pins are registered, so decode the phase being entered
    case (ph_d)
      PH_VRD0: begin
        sram_a_d   = BASE + vid_off;
        sram_oe_d  = 1'b0;
        sram_we_d  = 1'b1;
        sram_doe_d = 1'b0;
      end
      PH_VRD1: ;
      PH_WSET: begin
        sram_oe_d  = 1'b1;
        sram_we_d  = 1'b1;
        sram_doe_d = !fifo_empty;
        if (!fifo_empty) begin
          sram_a_d  = BASE + AW'(head.addr);
          sram_do_d = head.data;
        end
      end
      PH_WPULSE: begin
        sram_oe_d = 1'b1;
        sram_we_d = !sram_doe_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    vid_d  = (ph_q == PH_VRD1 && !sram_oe_q) ? sramDi : vid_q;
    slot_d = frame ? (slot & SLOT_MASK) : slot_q;
    ovf_d  = ((dlB & ~dl_b_q) ? 1'b0 : ovf_q) | drop;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph_q       <= PH_VRD0;
      slot_q     <= '0;
      vid_q      <= '0;
      ovf_q      <= 1'b0;
      dl_b_q     <= 1'b0;
      sram_a_q   <= '0;
      sram_oe_q  <= 1'b1;
      sram_we_q  <= 1'b1;
      sram_do_q  <= '0;
      sram_doe_q <= 1'b0;
    end else begin
      ph_q       <= ph_d;
      slot_q     <= slot_d;
      vid_q      <= vid_d;
      ovf_q      <= ovf_d;
      dl_b_q     <= dlB;
      sram_a_q   <= sram_a_d;
      sram_oe_q  <= sram_oe_d;
      sram_we_q  <= sram_we_d;
      sram_do_q  <= sram_do_d;
      sram_doe_q <= sram_doe_d;
    end
  end

  assign vidQ     = vid_q;
  assign overflow = ovf_q;
  assign busy     = dlB | ~fifo_empty;
  assign sramA    = sram_a_q;
  assign sramOe   = sram_oe_q;
  assign sramWe   = sram_we_q;
  assign sramDo   = sram_do_q;
  assign sramDoe  = sram_doe_q;

endmodule
